data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_if.sv | 20 ++
 rtl/data_memory.sv | 104 ++++++++++
 tb/tb_data_memory.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - request/response bundle between a cache and data_memory
interface data_memory_if;
    logic         mem_read;
    logic         mem_write;
    logic [11:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] DataBlock_m;
    logic         ready;
    logic         busy;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  DataBlock_m, ready, busy
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output DataBlock_m, ready, busy
    );
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-write / block-read backing store with fixed access latency
module data_memory #(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    data_memory_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t        state;
    logic [3:0]    count;
    logic [9:0]    word_addr;
    logic [31:0]  data_q;
    logic [127:0] block_q;
    logic         ready_q;
    logic         busy_q;
    logic         commit;

    logic [31:0]  mem [MEM_WORDS];

    // Storage has no reset; reset only forces the FSM to IDLE, which blocks the commit.
    assign commit = (state == WRITE_WAIT) && (count == 4'd0);

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[word_addr] <= data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 4'd0;
            word_addr <= 10'd0;
            data_q    <= 32'd0;
            block_q   <= 128'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.mem_write) begin
                        word_addr <= bus.addr[11:2];
                        data_q    <= bus.wdata;
                        count     <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        state     <= WRITE_WAIT;
                    end else if (bus.mem_read) begin
                        word_addr <= {bus.addr[11:4], 2'b00};
                        count     <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        state     <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (count == 4'd0) begin
                        block_q <= {mem[{word_addr[9:2], 2'd0}],
                                    mem[{word_addr[9:2], 2'd1}],
                                    mem[{word_addr[9:2], 2'd2}],
                                    mem[{word_addr[9:2], 2'd3}]};
                        ready_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                WRITE_WAIT: begin
                    if (count == 4'd0) begin
                        ready_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.DataBlock_m = block_q;
    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed vector bench for data_memory (LATENCY 4 and LATENCY 1 builds)
module tb_data_memory;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_if b0 ();
    data_memory_if b1 ();

    data_memory #(.LATENCY(4), .MEM_WORDS(1024)) dut (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    data_memory #(.LATENCY(1), .MEM_WORDS(1024)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    typedef struct {
        logic         rd;
        logic [11:0]  a;
        logic [31:0]  d;
        logic [127:0] exp;
    } vec_t;

    vec_t vq[$];
    int vectors = 0;
    int miscompares = 0;
    logic [127:0] exp_blk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [11:0] a, input logic [31:0] d);
        if (sel) begin
            b1.mem_read = rd; b1.mem_write = wr; b1.addr = a; b1.wdata = d;
        end else begin
            b0.mem_read = rd; b0.mem_write = wr; b0.addr = a; b0.wdata = d;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b1.ready : b0.ready;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? b1.busy : b0.busy;
    endfunction

    function automatic logic [127:0] blk(input bit sel);
        return sel ? b1.DataBlock_m : b0.DataBlock_m;
    endfunction

    // Counts edges from the accepting edge (inclusive) up to the one that raises ready.
    task automatic run_op(input bit sel, input logic rd, input logic wr,
                          input logic [11:0] a, input logic [31:0] d,
                          input int lat, input string nm);
        int n;
        int bc;
        bit got;
        n = 0; bc = 0; got = 0;
        drive(sel, rd, wr, a, d);
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (i == 0) drive(sel, 1'b0, 1'b0, 12'h3A8, 32'h0BAD0BAD);
            n++;
            if (bsy(sel)) bc++;
            if (rdy(sel)) got = 1;
        end
        chk({nm, " ready_edges"}, 128'(n), 128'(lat + 1));
        chk({nm, " busy_cycles"}, 128'(bc), 128'(lat + 1));
        @(posedge clk); #1;
        chk({nm, " after_done"}, {126'd0, rdy(sel), bsy(sel)}, 128'd0);
    endtask

    initial begin
        int pulses;
        drive(0, 0, 0, 12'h0, 32'h0);
        drive(1, 0, 0, 12'h0, 32'h0);

        vq.push_back('{1'b0, 12'h010, 32'hDEADBEEF, 128'h0});
        vq.push_back('{1'b0, 12'h014, 32'h55555555, 128'h0});
        vq.push_back('{1'b0, 12'h018, 32'h66666666, 128'h0});
        vq.push_back('{1'b0, 12'h01C, 32'h77777777, 128'h0});
        vq.push_back('{1'b1, 12'h01C, 32'h0, 128'hDEADBEEF_55555555_66666666_77777777});
        vq.push_back('{1'b0, 12'hFF0, 32'h11111111, 128'h0});
        vq.push_back('{1'b0, 12'hFF4, 32'h22222222, 128'h0});
        vq.push_back('{1'b0, 12'hFF8, 32'h33333333, 128'h0});
        vq.push_back('{1'b0, 12'hFFC, 32'h44444444, 128'h0});
        vq.push_back('{1'b1, 12'hFF4, 32'h0, 128'h11111111_22222222_33333333_44444444});
        vq.push_back('{1'b0, 12'h040, 32'hCAFEF00D, 128'h0});
        vq.push_back('{1'b0, 12'h044, 32'h00000044, 128'h0});
        vq.push_back('{1'b0, 12'h048, 32'h00000048, 128'h0});
        vq.push_back('{1'b0, 12'h04C, 32'h0000004C, 128'h0});
        vq.push_back('{1'b1, 12'h04C, 32'h0, 128'hCAFEF00D_00000044_00000048_0000004C});
        vq.push_back('{1'b0, 12'h020, 32'h00000000, 128'h0});
        vq.push_back('{1'b0, 12'h024, 32'h00000024, 128'h0});
        vq.push_back('{1'b0, 12'h028, 32'h00000028, 128'h0});
        vq.push_back('{1'b0, 12'h02C, 32'h0000002C, 128'h0});
        vq.push_back('{1'b1, 12'h028, 32'h0, 128'h00000000_00000024_00000028_0000002C});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state0", {blk(0)[125:0], rdy(0), bsy(0)}, 128'd0);
        chk("reset_state1", {blk(1)[125:0], rdy(1), bsy(1)}, 128'd0);
        rst_n = 1'b1;
        exp_blk = 128'd0;

        foreach (vq[i]) begin
            run_op(0, vq[i].rd, !vq[i].rd, vq[i].a, vq[i].d, 4, $sformatf("vec%0d", i));
            if (vq[i].rd) exp_blk = vq[i].exp;
            chk($sformatf("vec%0d block", i), blk(0), exp_blk);
        end

        // Simultaneous read+write: write wins, block untouched.
        run_op(0, 1'b1, 1'b1, 12'h020, 32'hA5A5A5A5, 4, "both_req");
        chk("both_req block", blk(0), exp_blk);
        exp_blk = 128'hA5A5A5A5_00000024_00000028_0000002C;
        run_op(0, 1'b1, 1'b0, 12'h020, 32'h0, 4, "both_req readback");
        chk("both_req readback block", blk(0), exp_blk);

        // Requests toggled during READ_WAIT are ignored.
        pulses = 0;
        drive(0, 1'b1, 1'b0, 12'h010, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (rdy(0)) pulses++;
            case (i)
                1: drive(0, 1'b0, 1'b1, 12'h014, 32'h0);
                2: drive(0, 1'b0, 1'b0, 12'h3F0, 32'h0);
                3: drive(0, 1'b0, 1'b1, 12'h014, 32'h0);
                4: drive(0, 1'b0, 1'b0, 12'h000, 32'h0);
                default: ;
            endcase
        end
        exp_blk = 128'hDEADBEEF_55555555_66666666_77777777;
        chk("toggle pulses", 128'(pulses), 128'd1);
        chk("toggle block", blk(0), exp_blk);
        run_op(0, 1'b1, 1'b0, 12'h014, 32'h0, 4, "toggle readback");
        chk("toggle readback block", blk(0), exp_blk);

        // Reset during WRITE_WAIT aborts the write.
        drive(0, 1'b0, 1'b1, 12'h040, 32'h12345678);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 12'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort immediate", {blk(0)[125:0], rdy(0), bsy(0)}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rdy(0) || bsy(0)) pulses++;
        end
        chk("abort no_pulse", 128'(pulses), 128'd0);
        exp_blk = 128'hCAFEF00D_00000044_00000048_0000004C;
        run_op(0, 1'b1, 1'b0, 12'h040, 32'h0, 4, "abort readback");
        chk("abort readback block", blk(0), exp_blk);

        // LATENCY=1 build.
        run_op(1, 1'b0, 1'b1, 12'h100, 32'h0BADCAFE, 1, "lat1 w0");
        chk("lat1 w0 block", blk(1), 128'd0);
        run_op(1, 1'b0, 1'b1, 12'h104, 32'h00000001, 1, "lat1 w1");
        run_op(1, 1'b0, 1'b1, 12'h108, 32'h00000002, 1, "lat1 w2");
        run_op(1, 1'b0, 1'b1, 12'h10C, 32'h00000003, 1, "lat1 w3");
        run_op(1, 1'b1, 1'b0, 12'h108, 32'h0, 1, "lat1 rd");
        chk("lat1 rd block", blk(1), 128'h0BADCAFE_00000001_00000002_00000003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
